// File: rtl/fft_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_mult_pkg
// Description : Shared types and helpers for the sign-magnitude multiplier
//               used in the FFT butterfly datapath.
//               - state_t : control FSM encoding (IDLE/BUSY/DONE)
//               - sm_sign : product sign with negative zero folded to +0
// Revision    : 1.0 - initial release
// ============================================================================
package fft_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // A zero magnitude always yields a positive sign, whatever the operands.
    function automatic logic sm_sign(input logic sa, input logic sb,
                                     input logic mag_nonzero);
        return (sa ^ sb) & mag_nonzero;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm_mult_shift_add.sv
`default_nettype none
// ============================================================================
// Module      : sm_mult_shift_add
// Description : Combinational single iteration of the shift-add magnitude
//               multiplier.
// Ports       : acc         in  2*MAG_W  running partial product
//               mcand       in  2*MAG_W  shifted multiplicand
//               mplier      in  MAG_W    remaining multiplier bits
//               acc_next    out 2*MAG_W  acc (+ mcand when mplier[0])
//               mcand_next  out 2*MAG_W  mcand << 1
//               mplier_next out MAG_W    mplier >> 1
//               mplier_zero out 1        mplier_next == 0
// Revision    : 1.0 - initial release
// ============================================================================
module sm_mult_shift_add #(
    parameter int MAG_W = 8
) (
    input  logic [2*MAG_W-1:0] acc,
    input  logic [2*MAG_W-1:0] mcand,
    input  logic [MAG_W-1:0]   mplier,
    output logic [2*MAG_W-1:0] acc_next,
    output logic [2*MAG_W-1:0] mcand_next,
    output logic [MAG_W-1:0]   mplier_next,
    output logic               mplier_zero
);

    // The 2*MAG_W accumulator holds (2^MAG_W-1)^2, so the sum never carries out.
    assign acc_next    = mplier[0] ? (acc + mcand) : acc;
    assign mcand_next  = {mcand[2*MAG_W-2:0], 1'b0};
    assign mplier_next = {1'b0, mplier[MAG_W-1:1]};
    assign mplier_zero = (mplier_next == '0);

endmodule
`default_nettype wire

// File: rtl/sm_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : sm_seq_multiplier
// Description : Iterative sign-magnitude multiplier, one multiplier bit per
//               cycle, valid/ready handshakes on input and output.
//               Optional macro SM_MULT_EARLY_EXIT_EN: leave BUSY as soon as
//               the remaining multiplier bits are all zero.
// Ports       : clk       in  1          system clock, rising edge
//               rst_n     in  1          asynchronous active-low reset
//               in_valid  in  1          operands present
//               in_ready  out 1          operands accepted (IDLE only)
//               a, b      in  MAG_W+1    {sign, magnitude} operands
//               out_valid out 1          product valid, held until accepted
//               out_ready in  1          downstream accepts product
//               prdct     out 2*MAG_W+1  {sign, magnitude} product
//               busy      out 1          high in BUSY or DONE
// Revision    : 1.0 - initial release
// ============================================================================
module sm_seq_multiplier
    import fft_mult_pkg::*;
#(
    parameter int MAG_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAG_W:0]     a,
    input  logic [MAG_W:0]     b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*MAG_W:0]   prdct,
    output logic               busy
);

    localparam int CNT_W = (MAG_W > 1) ? $clog2(MAG_W) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(MAG_W - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [2*MAG_W-1:0]   r_acc;
    logic [2*MAG_W-1:0]   r_mcand;
    logic [MAG_W-1:0]     r_mplier;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_sgn;
    logic [2*MAG_W:0]     r_prdct;

    logic [2*MAG_W-1:0]   w_acc_next;
    logic [2*MAG_W-1:0]   w_mcand_next;
    logic [MAG_W-1:0]     w_mplier_next;
    logic                 w_mplier_zero;
    logic                 w_last;

    sm_mult_shift_add #(
        .MAG_W (MAG_W)
    ) u_shift_add (
        .acc         (r_acc),
        .mcand       (r_mcand),
        .mplier      (r_mplier),
        .acc_next    (w_acc_next),
        .mcand_next  (w_mcand_next),
        .mplier_next (w_mplier_next),
        .mplier_zero (w_mplier_zero)
    );

`ifdef SM_MULT_EARLY_EXIT_EN
    // Once no multiplier bits remain, further iterations only shift mcand.
    assign w_last = (r_cnt == c_CNT_LAST) || w_mplier_zero;
`else
    logic w_unused_mplier_zero;
    assign w_unused_mplier_zero = w_mplier_zero;
    assign w_last = (r_cnt == c_CNT_LAST);
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = BUSY;
            BUSY:    if (w_last)   w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        in_ready  = (r_state == IDLE);
        busy      = (r_state != IDLE);
        out_valid = (r_state == DONE);
    end

    assign prdct = r_prdct;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_sgn    <= 1'b0;
            r_prdct  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= {{MAG_W{1'b0}}, a[MAG_W-1:0]};
                        r_mplier <= b[MAG_W-1:0];
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_sgn    <= a[MAG_W] ^ b[MAG_W];
                    end
                end
                BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= w_mcand_next;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt + 1'b1;
                    // r_sgn already holds sa^sb; the helper only applies the
                    // zero-magnitude fold.
                    if (w_last) begin
                        r_prdct <= {sm_sign(r_sgn, 1'b0, |w_acc_next), w_acc_next};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sm_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_sm_seq_multiplier
// Description : Directed and randomised self-checking bench for
//               sm_seq_multiplier (MAG_W = 8). Latency expectations follow
//               SM_MULT_EARLY_EXIT_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sm_seq_multiplier;

    localparam int MAG_W = 8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  a;
    logic [8:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] prdct;
    logic        busy;

    int n_checks;
    int n_errors;

    sm_seq_multiplier #(
        .MAG_W (MAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prdct     (prdct),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference product computed arithmetically, independent of shift-add.
    function automatic logic [16:0] ref_prod(input logic [8:0] ra, input logic [8:0] rb);
        logic [15:0] m;
        m = ra[7:0] * rb[7:0];
        return {(ra[8] ^ rb[8]) & (m != 16'd0), m};
    endfunction

    function automatic int ref_lat(input logic [8:0] rb);
`ifdef SM_MULT_EARLY_EXIT_EN
        int l;
        l = 1;
        for (int i = 0; i < MAG_W; i++) if (rb[i]) l = i + 1;
        return l;
`else
        return MAG_W;
`endif
    endfunction

    // Issue one op, wait (bounded) for out_valid, check product and latency.
    // Leaves the DUT in DONE with out_valid high.
    task automatic do_op(input string tag, input logic [8:0] ia, input logic [8:0] ib,
                         input logic [16:0] exp_p, input int exp_lat);
        int lat;
        @(negedge clk);
        a = ia; b = ib; in_valid = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_prdct"}, prdct, exp_p);
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_hs_ready"}, in_ready, 1);
        check({tag, "_hs_valid"}, out_valid, 0);
    endtask

    initial begin
        logic [8:0]  ra, rb;
        logic        quiet;
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_prdct", prdct, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;

        // 1: +5 * +7
        do_op("t1", 9'h005, 9'h007, 17'h00023, ref_lat(9'h007));
        handshake("t1");

        // 2: -255 * +255, second accept blocked while DONE
        do_op("t2", 9'h1FF, 9'h0FF, 17'h1FE01, ref_lat(9'h0FF));
        @(negedge clk);
        a = 9'h002; b = 9'h002; in_valid = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("t2_blocked_ready", in_ready, 0);
            check("t2_busy", busy, 1);
            check("t2_hold", prdct, 17'h1FE01);
        end
        handshake("t2");

        // 3: -3 * -0 -> canonical +0
        do_op("t3", 9'h103, 9'h100, 17'h00000, ref_lat(9'h100));
        handshake("t3");

        // 4: backpressure, 12 * -10 = -120
        do_op("t4", 9'h00C, 9'h10A, 17'h10078, ref_lat(9'h10A));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t4_bp_valid", out_valid, 1);
            check("t4_bp_prdct", prdct, 17'h10078);
        end
        handshake("t4");
        check("t4_prdct_kept", prdct, 17'h10078);

        // 5: reset mid-BUSY discards the op
        @(negedge clk);
        a = 9'h00A; b = 9'h0FF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_ready", in_ready, 1);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_prdct", prdct, 0);
        @(negedge clk) rst_n = 1'b1;
        quiet = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (out_valid || busy) quiet = 1'b0;
        end
        check("t5_no_output", quiet, 1);
        do_op("t5_4x4", 9'h004, 9'h004, 17'h00010, ref_lat(9'h004));
        handshake("t5");

        // 6: latency extremes
        do_op("t6_b1", 9'h0C8, 9'h001, 17'h000C8, ref_lat(9'h001));
        handshake("t6a");
        do_op("t6_b80", 9'h003, 9'h080, 17'h00180, ref_lat(9'h080));
        handshake("t6b");

        // Random sweep against the arithmetic reference
        for (int i = 0; i < 1000; i++) begin
            ra = 9'($urandom);
            rb = 9'($urandom);
            do_op("rnd", ra, rb, ref_prod(ra, rb), ref_lat(rb));
            handshake("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
